instruction_fetch_unit: RTL
===========================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, instruction substituted on fetch failure.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fetch_RequestState  input  1  one-hot pipeline strobe: issue instruction read.
REQ-006 fetch_ReceiveState  input  1  one-hot pipeline strobe: capture read data.
REQ-007 writebackState  input  1  one-hot pipeline strobe: commit next PC.
REQ-008 branch_taken  input  1  sampled in writebackState; select branch_target.
REQ-009 branch_target  input  32  next PC when branch_taken.
REQ-010 mem_rdata  input  32  instruction memory read data.
REQ-011 mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-012 mem_req  output  1  instruction read request.
REQ-013 mem_addr  output  32  read address, equals pc.
REQ-014 pc  output  32  address of current instruction.
REQ-015 instruction  output  32  captured instruction register.
REQ-016 instr_valid  output  1  instruction holds real memory data (not substituted).
REQ-017 fetch_error  output  1  sticky: missing rvalid or out-of-sequence strobe.
REQ-018 misaligned_target  output  1  sticky: branch_target[1:0] != 0 on a taken branch.
REQ-019 retired_count  output  32  count of completed writebackState cycles.

Function
REQ-020 FSM states IDLE, WAIT_DATA; the only transitions are IDLE->WAIT_DATA and WAIT_DATA->IDLE as defined below.
REQ-021 In IDLE, mem_req = fetch_RequestState (combinational), mem_addr = pc; on that edge FSM -> WAIT_DATA.
REQ-022 mem_req SHALL be 0 in WAIT_DATA; exactly one request per instruction.
REQ-023 In WAIT_DATA with fetch_ReceiveState and mem_rvalid: instruction <= mem_rdata, instr_valid <= 1, FSM -> IDLE.
REQ-024 In WAIT_DATA with fetch_ReceiveState and !mem_rvalid: instruction <= NOP_INSTR, instr_valid <= 0, fetch_error <= 1, FSM -> IDLE.
REQ-025 fetch_ReceiveState while IDLE: no capture, fetch_error <= 1, FSM stays IDLE.
REQ-026 fetch_RequestState while WAIT_DATA: no new request, fetch_error <= 1, FSM -> IDLE.
REQ-027 mem_rvalid outside a WAIT_DATA receive cycle SHALL be ignored.
REQ-028 writebackState: if branch_taken and branch_target[1:0]==0, pc <= branch_target; else pc <= pc + 4 (mod 2^32).
REQ-029 Taken branch with branch_target[1:0]!=0: pc <= pc + 4, misaligned_target <= 1.
REQ-030 PC wrap: pc 32'hFFFF_FFFC + 4 -> 32'h0000_0000, no flag.
REQ-031 writebackState: retired_count <= retired_count + 1, wraps at 2^32.
REQ-032 pc, instruction, instr_valid change only on the edges defined above; held otherwise.
REQ-033 Latency: instruction valid the cycle after fetch_ReceiveState; pc updated the cycle after writebackState.

Reset
REQ-034 Reset SHALL take priority over all other inputs in the same cycle.
REQ-035 On reset: FSM=IDLE, pc=RESET_PC, instruction=NOP_INSTR, instr_valid=0, fetch_error=0, misaligned_target=0, retired_count=0.
REQ-036 Reset while in WAIT_DATA SHALL abandon the fetch; a following mem_rvalid SHALL be ignored.
REQ-037 mem_req SHALL be 0 during any reset cycle.

Structure
REQ-038 pipeline_pkg SHALL hold RESET_PC default, NOP_INSTR default, and the fetch FSM state type.
REQ-039 One sub-module, pc_update_unit, SHALL hold the pc register and next-PC/misalignment logic.

Verification
REQ-040 Reset, 6-state strobe cycle, mem_rvalid=1, mem_rdata=32'h0050_0093 -> mem_req one cycle, mem_addr=0, instruction=32'h0050_0093, instr_valid=1, pc=4, retired_count=1.
REQ-041 Receive cycle with mem_rvalid=0 -> instruction=32'h0000_0013, instr_valid=0, fetch_error=1 until reset.
REQ-042 Writeback with branch_taken=1, branch_target=32'h0000_0100 -> pc=32'h100; next request mem_addr=32'h100.
REQ-043 branch_target=32'h0000_0102 taken from pc=8 -> pc=12, misaligned_target=1.
REQ-044 pc=32'hFFFF_FFFC, writeback no branch -> pc=0, no flags set.
REQ-045 Reset asserted in WAIT_DATA, mem_rvalid=1 next cycle -> instruction=NOP_INSTR, instr_valid=0, pc=RESET_PC, mem_req=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline definitions: reset defaults, the fetch FSM state type
// and the sequential next-PC helper.
package pipeline_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH_IDLE      = 1'b0,
    FETCH_WAIT_DATA = 1'b1
  } fetch_state_e;

  // Sequential successor; wraps modulo 2^32 with no overflow flag.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pc_update_unit.sv
// PC register with next-PC selection and sticky misaligned-branch flag;
// advances only on the writeback strobe.
module pc_update_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        writeback,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic        misaligned_target
);

  logic [31:0] pc_q, pc_d;
  logic        misaligned_q, misaligned_d;
  logic        target_ok;

  assign target_ok = (branch_target[1:0] == 2'b00);

  always_comb begin
    pc_d         = pc_q;
    misaligned_d = misaligned_q;
    if (writeback) begin
      // A misaligned target is dropped in favour of the fall-through PC.
      if (branch_taken && target_ok) pc_d = branch_target;
      else                           pc_d = seq_pc(pc_q);
      if (branch_taken && !target_ok) misaligned_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc                = pc_q;
  assign misaligned_target = misaligned_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: one memory request per instruction, captures the reply
// (or a NOP on a missing reply), and tracks retired writeback cycles.
module instruction_fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_RequestState,
  input  logic        fetch_ReceiveState,
  input  logic        writebackState,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic        fetch_error,
  output logic        misaligned_target,
  output logic [31:0] retired_count
);

  fetch_state_e state_q, state_d;
  logic [31:0]  instruction_q, instruction_d;
  logic         instr_valid_q, instr_valid_d;
  logic         fetch_error_q, fetch_error_d;
  logic [31:0]  retired_q, retired_d;

  pc_update_unit #(.RESET_PC(RESET_PC)) u_pc (
    .clk               (clk),
    .reset             (reset),
    .writeback         (writebackState),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .pc                (pc),
    .misaligned_target (misaligned_target)
  );

  // Request is combinational from the strobe but suppressed during reset.
  assign mem_req  = !reset && (state_q == FETCH_IDLE) && fetch_RequestState;
  assign mem_addr = pc;

  always_comb begin
    state_d       = state_q;
    instruction_d = instruction_q;
    instr_valid_d = instr_valid_q;
    fetch_error_d = fetch_error_q;
    retired_d     = retired_q;
    case (state_q)
      FETCH_IDLE: begin
        if (fetch_RequestState) state_d = FETCH_WAIT_DATA;
        if (fetch_ReceiveState) fetch_error_d = 1'b1;
      end
      FETCH_WAIT_DATA: begin
        if (fetch_ReceiveState) begin
          state_d = FETCH_IDLE;
          if (mem_rvalid) begin
            instruction_d = mem_rdata;
            instr_valid_d = 1'b1;
          end else begin
            instruction_d = NOP_INSTR;
            instr_valid_d = 1'b0;
            fetch_error_d = 1'b1;
          end
        end
        // A second request while waiting abandons the outstanding fetch.
        if (fetch_RequestState) begin
          state_d       = FETCH_IDLE;
          fetch_error_d = 1'b1;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
    if (writebackState) retired_d = retired_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH_IDLE;
      instruction_q <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      fetch_error_q <= 1'b0;
      retired_q     <= '0;
    end else begin
      state_q       <= state_d;
      instruction_q <= instruction_d;
      instr_valid_q <= instr_valid_d;
      fetch_error_q <= fetch_error_d;
      retired_q     <= retired_d;
    end
  end

  assign instruction   = instruction_q;
  assign instr_valid   = instr_valid_q;
  assign fetch_error   = fetch_error_q;
  assign retired_count = retired_q;

endmodule
